// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the native memory arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational rotate-priority selector (first set bit from ptr up). Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from the far end back towards ptr so the nearest hit wins.
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : round-robin sharing of one native memory port, with watchdog. Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N_REQ          = 2,
    parameter  int ADDR_W         = 32,
    parameter  int DATA_W         = 32,
    parameter  int TIMEOUT_CYCLES = 0,
    localparam int IDX_W          = idx_width(N_REQ),
    localparam int STRB_W         = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ*STRB_W-1:0]   req_wstrb,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [STRB_W-1:0]         mem_wstrb,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      timeout
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [DATA_W-1:0] BAD_WORD = DATA_W'(BAD_DATA);

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  wd_cnt;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic [N_REQ-1:0]  grant_onehot;
    logic [IDX_W-1:0]  next_ptr;
    logic              wd_last;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign sel_addr     = req_addr [int'(pick_idx) * ADDR_W +: ADDR_W];
    assign sel_wdata    = req_wdata[int'(pick_idx) * DATA_W +: DATA_W];
    assign sel_wstrb    = req_wstrb[int'(pick_idx) * STRB_W +: STRB_W];
    assign grant_onehot = N_REQ'(1) << grant_id;
    assign next_ptr     = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    // Terminal count is the last BUSY cycle without a response; a response
    // arriving in that same cycle takes priority in the FSM below.
    assign wd_last = (TIMEOUT_CYCLES > 0) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            wd_cnt    <= '0;
            req_ready <= '0;
            req_rdata <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            grant_id  <= '0;
            timeout   <= 1'b0;
        end else begin
            req_ready <= '0;
            timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        mem_valid <= 1'b1;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_wstrb <= sel_wstrb;
                        grant_id  <= pick_idx;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        req_rdata <= mem_rdata;
                        mem_valid <= 1'b0;
                        req_ready <= grant_onehot;
                        state     <= ST_RESP;
                    end else if (wd_last) begin
                        req_rdata <= BAD_WORD;
                        mem_valid <= 1'b0;
                        req_ready <= grant_onehot;
                        timeout   <= 1'b1;
                        state     <= ST_RESP;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rr_ptr <= next_ptr;
                    wd_cnt <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed and random checks of mem_arbiter against a grant/response model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [DW-1:0]     req_rdata;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_wstrb;
    logic [DW-1:0]     mem_rdata = '0;
    logic              grant_id;
    logic              timeout;

    logic [AW-1:0] a  [N];
    logic [DW-1:0] wd [N];
    logic [SW-1:0] ws [N];

    int vectors     = 0;
    int miscompares = 0;
    int rr_model    = 0;

    assign req_addr  = {a[1], a[0]};
    assign req_wdata = {wd[1], wd[0]};
    assign req_wstrb = {ws[1], ws[0]};

    mem_arbiter #(
        .N_REQ          (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // Rotate-priority: first valid requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(rr_model + k) % N]) return (rr_model + k) % N;
        end
        return -1;
    endfunction

    // One transaction; memory answers on BUSY cycle 'delay' (never if delay > TO).
    task automatic transfer(input logic [N-1:0] m, input int delay, input logic [DW-1:0] rd);
        int            g;
        int            c;
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_rd;
        g = model_pick(m);
        req_valid = m;
        @(posedge clk); #1;
        chk("issue_valid", mem_valid, 1);
        chk("grant_id",    grant_id, g);
        chk("issue_addr",  mem_addr, a[g]);
        chk("issue_wdata", mem_wdata, wd[g]);
        chk("issue_wstrb", mem_wstrb, ws[g]);
        c = 0;
        while (1) begin
            c++;
            mem_ready = (c == delay);
            mem_rdata = (c == delay) ? rd : $urandom;
            @(posedge clk); #1;
            if (c == delay || c == TO) break;
            chk("busy_valid", mem_valid, 1);
            chk("busy_addr",  mem_addr, a[g]);
            chk("busy_wdata", mem_wdata, wd[g]);
            chk("busy_wstrb", mem_wstrb, ws[g]);
            chk("busy_ready", req_ready, 0);
        end
        mem_ready = 1'b0;
        exp_ready = '0;
        exp_ready[g] = 1'b1;
        exp_rd = (delay <= TO) ? rd : 32'hDEAD_BEEF;
        chk("resp_ready",   req_ready, exp_ready);
        chk("resp_rdata",   req_rdata, exp_rd);
        chk("resp_timeout", timeout, (delay > TO) ? 1 : 0);
        chk("resp_valid",   mem_valid, 0);
        req_valid[g] = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready",   req_ready, 0);
        chk("idle_timeout", timeout, 0);
        chk("idle_valid",   mem_valid, 0);
        chk("idle_rdata",   req_rdata, exp_rd);
        rr_model = (g + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = '0; wd[i] = '0; ws[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",   mem_valid, 0);
        chk("rst_ready",   req_ready, 0);
        chk("rst_grant",   grant_id, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rdata",   req_rdata, 0);
        chk("rst_addr",    mem_addr, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single read from requester 0
        a[0] = 32'h100; wd[0] = '0; ws[0] = '0;
        transfer(2'b01, 3, 32'h1234_5678);

        // Contention: both continuously valid, grants must alternate
        for (int i = 0; i < 6; i++) begin
            a[0] = $urandom; a[1] = $urandom; wd[0] = $urandom; wd[1] = $urandom;
            transfer(2'b11, $urandom_range(1, 4), $urandom);
        end

        // Write pass-through from requester 1
        a[1] = 32'h2004; wd[1] = 32'hA5A5_5A5A; ws[1] = 4'b0011;
        transfer(2'b10, 5, $urandom);

        // Watchdog abort, then response landing on the terminal cycle
        a[0] = 32'h300; ws[0] = '0;
        transfer(2'b01, 20, $urandom);
        transfer(2'b01, TO, 32'hCAFE_F00D);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < N; r++) begin
                a[r] = $urandom; wd[r] = $urandom; ws[r] = SW'($urandom);
            end
            transfer(N'($urandom_range(1, 3)), $urandom_range(1, 10), $urandom);
        end

        // Asynchronous reset in the middle of BUSY
        a[1] = 32'h4000;
        req_valid = 2'b10;
        @(posedge clk); #1;
        chk("pre_rst_grant", grant_id, 1);
        chk("pre_rst_valid", mem_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", mem_valid, 0);
        chk("async_rst_ready", req_ready, 0);
        chk("async_rst_grant", grant_id, 0);
        req_valid = '0;
        rr_model = 0;
        @(negedge clk);
        resetn = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", mem_valid, 0);
            chk("post_rst_ready", req_ready, 0);
            chk("post_rst_rdata", req_rdata, 0);
        end
        mem_ready = 1'b0;

        // Pointer must restart at 0 after reset
        a[0] = $urandom; a[1] = $urandom;
        transfer(2'b11, 2, $urandom);
        transfer(2'b11, 1, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter sharing one picorv32-native memory port between N_REQ requesters (e.g. CPU instruction/data path, debug/loader master, DMA).
- Its downstream port drives the native-to-AXI4-lite adapter in front of axi_memory.
- Single outstanding transaction.
- Optional watchdog aborts transfers the memory never answers.

Parameters:
N_REQ, 2, number of requesters (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width DATA_W/8
TIMEOUT_CYCLES, 0, BUSY cycles before abort; 0 disables watchdog
IDX_W, localparam max(1,$clog2(N_REQ)), grant index width

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request
req_ready  output  N_REQ  per-requester completion pulse
req_addr  input  N_REQ*ADDR_W  packed addresses, requester i at slice i
req_wdata  input  N_REQ*DATA_W  packed write data
req_wstrb  input  N_REQ*DATA_W/8  packed strobes; all-zero = read
req_rdata  output  DATA_W  read data, broadcast, valid with req_ready
mem_valid  output  1  downstream request
mem_ready  input  1  downstream completion
mem_addr  output  ADDR_W  downstream address
mem_wdata  output  DATA_W  downstream write data
mem_wstrb  output  DATA_W/8  downstream strobe
mem_rdata  input  DATA_W  downstream read data
grant_id  output  IDX_W  index of current/last granted requester
timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
- One clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; rr_ptr 0; watchdog counter 0.
- All outputs are registered.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from rr_ptr upward, modulo N_REQ.
  - Latch that requester's addr/wdata/wstrb into mem_*; set mem_valid=1 and grant_id; go to BUSY.
  - Latency: req_valid sampled high at edge k gives mem_valid high after edge k.
- BUSY:
  - mem_valid and mem_* stay stable; req_* changes are ignored.
  - On mem_ready=1: capture mem_rdata into req_rdata, clear mem_valid, go to RESP.
  - Watchdog (TIMEOUT_CYCLES>0): counter increments each BUSY cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES: clear mem_valid, set req_rdata=BAD_DATA (32'hDEAD_BEEF), pulse timeout, go to RESP.
  - If mem_ready and the timeout terminal count coincide, mem_ready wins and timeout stays 0.
- RESP:
  - req_ready[grant_id]=1 for exactly one cycle; all other req_ready bits are 0.
  - rr_ptr = (grant_id+1) mod N_REQ; watchdog counter cleared; next state IDLE.
- Requester protocol (picorv32 native): hold req_valid and payload until req_ready, then drop req_valid in the cycle after.
- A requester dropping req_valid while granted is a protocol violation. The arbiter still completes the transfer and pulses req_ready.
- req_rdata holds its value until the next capture. For writes it carries mem_rdata as returned.
- Minimum cycle per transfer: IDLE, BUSY (≥1 cycle), RESP = 3 cycles. No back-to-back grant without an IDLE cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0.
- N_REQ=1: always grants 0; rr_ptr is constant 0.
- Reset asserted mid-transfer: immediate return to reset values. A downstream response arriving after reset release while in IDLE is ignored.
- mem_ready while IDLE or RESP: ignored.

Decomposition:
- Package mem_arb_pkg:
  - state enum (ST_IDLE, ST_BUSY, ST_RESP)
  - BAD_DATA constant
  - function for IDX_W computation
- Sub-module rr_pick: combinational rotate-priority selector.
  - Inputs: request vector, rr_ptr.
  - Outputs: any, index.
  - Also reusable for a future AXI-side arbiter.

Test Plan:
- Single read: req_valid=2'b01, addr 0x100. Memory answers mem_ready after 3 cycles with 0x12345678 -> mem_valid rises 1 cycle after request; req_ready=2'b01 for one cycle with req_rdata=0x12345678; grant_id=0.
- Contention: both valid continuously, 6 transfers -> grant order 0,1,0,1,0,1; mem_addr always matches the granted slice; never two req_ready bits set.
- Write pass-through: requester 1 with wstrb 4'b0011, wdata 0xA5A5_5A5A, addr 0x2004 -> mem_wstrb/mem_wdata/mem_addr exact and stable through BUSY; req_ready[1] pulse.
- Watchdog: TIMEOUT_CYCLES=8, mem_ready held 0 -> after 8 BUSY cycles mem_valid=0, timeout pulse, req_ready pulse, req_rdata=0xDEADBEEF. Repeat with mem_ready on cycle 8 -> timeout=0, real data returned.
- Reset mid-BUSY: assert resetn=0 asynchronously -> mem_valid, req_ready, grant_id go 0 without a clock edge; after release with no requests, no transaction is issued.
